ac_reg: RTL and testbench

//   Accumulator register (AC) of the simple datapath CPU.
//   - Captures the 8-bit data bus on a write strobe.
//   - Holds the value until the next write or reset.
//   - Presents the value back to the bus only while the read strobe is high.
//   - Drives two status flags for the control unit.

---
 rtl/ac_reg.sv | 42 ++++
 tb/tb_ac_reg.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ac_reg.sv
// Accumulator register of the simple datapath CPU: loads the bus on a write strobe,
// gates its contents onto the bus while the read strobe is high, and drives zero/negative flags.
module ac_reg #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ac_in,
  input  logic             wac,
  input  logic             rac,
  output logic [WIDTH-1:0] ac_out,
  output logic             ac_zero,
  output logic             ac_neg
);

  logic [WIDTH-1:0] ac_q;
  logic [WIDTH-1:0] ac_d;

  always_comb begin
    ac_d = ac_q;
    if (wac) begin
      ac_d = ac_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac_q <= RESET_VALUE;
    end else begin
      ac_q <= ac_d;
    end
  end

  // Bus side is gated to zero rather than tri-stated; flags ignore rac.
  always_comb begin
    ac_out  = rac ? ac_q : '0;
    ac_zero = (ac_q == '0);
    ac_neg  = ac_q[WIDTH-1];
  end

endmodule

// File: tb/tb_ac_reg.sv
// Bench for ac_reg: directed scenarios followed by randomized strobes, checked against a
// plain integer model of the stored accumulator value.
module tb_ac_reg;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RESET_VALUE = 8'h00;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] ac_in;
  logic             wac;
  logic             rac;
  logic [WIDTH-1:0] ac_out;
  logic             ac_zero;
  logic             ac_neg;

  int checks;
  int errors;
  int model_ac;

  ac_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ac_in  (ac_in),
    .wac    (wac),
    .rac    (rac),
    .ac_out (ac_out),
    .ac_zero(ac_zero),
    .ac_neg (ac_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs come straight from the stored value and the read strobe.
  task automatic check_all(input string tag);
    int exp_out;
    exp_out = rac ? model_ac : 0;
    check({tag, ".out"}, int'(ac_out), exp_out);
    check({tag, ".zero"}, int'(ac_zero), (model_ac == 0) ? 1 : 0);
    check({tag, ".neg"}, int'(ac_neg), (model_ac >= 128) ? 1 : 0);
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) model_ac = int'(RESET_VALUE);
  endtask

  // One clock edge; inputs are stable here since they only change 1-2 ns after an edge.
  task automatic step();
    int nxt;
    if (reset) nxt = int'(RESET_VALUE);
    else if (wac) nxt = int'(ac_in);
    else nxt = model_ac;
    @(posedge clk);
    #1;
    model_ac = nxt;
  endtask

  task automatic write(input logic [WIDTH-1:0] d);
    ac_in = d;
    wac   = 1'b1;
    step();
    wac   = 1'b0;
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    model_ac = 0;
    wac      = 1'b0;
    rac      = 1'b1;
    ac_in    = '0;
    set_reset(1'b1);

    // 1. Power-up: reset visible before any clock edge.
    #2;
    check_all("pwr_rac1");
    step();
    set_reset(1'b0);
    rac = 1'b0;
    #1;
    check_all("pwr_rac0");

    // 2. Write then read.
    write(8'h01);
    rac = 1'b1;
    #1;
    check_all("wr_rac1");
    rac = 1'b0;
    #1;
    check_all("wr_rac0");

    // 3. Hold, reset, then deferred load.
    ac_in = 8'h02;
    rac   = 1'b1;
    step();
    check_all("hold");
    set_reset(1'b1);
    #1;
    check_all("hold_rst");
    step();
    set_reset(1'b0);
    write(8'h02);
    check_all("hold_load");

    // 4. Simultaneous strobes: old value before the edge, new after.
    ac_in = 8'h03;
    step();
    wac = 1'b1;
    #1;
    check_all("both_pre");
    check("both_pre_val", int'(ac_out), 8'h02);
    step();
    check_all("both_post");
    check("both_post_val", int'(ac_out), 8'h03);
    for (int i = 0; i < 10; i++) begin
      step();
      check_all("both_hold");
    end
    wac = 1'b0;

    // 5. Async reset mid-cycle, then reset overriding a write.
    #2;
    set_reset(1'b1);
    #1;
    check_all("async_rst");
    check("async_rst_val", int'(ac_out), 8'h00);
    ac_in = 8'hFF;
    wac   = 1'b1;
    step();
    check_all("rst_over_wac");
    wac = 1'b0;
    set_reset(1'b0);
    #1;

    // 6. Flags.
    write(8'h80);
    check_all("flag_neg");
    check("flag_neg_bit", int'(ac_neg), 1);
    write(8'h00);
    check_all("flag_zero");
    check("flag_zero_bit", int'(ac_zero), 1);

    // Randomized strobes, data and occasional mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      set_reset($urandom_range(15) == 0);
      wac   = $urandom_range(1);
      rac   = $urandom_range(1);
      ac_in = WIDTH'($urandom);
      #1;
      check_all("rand_pre");
      step();
      check_all("rand_post");
    end
    set_reset(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
